// File: rtl/sw_pio_irq.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture, interrupt mask and level IRQ.
// Optional per-bit debounce filter enabled by defining SW_PIO_IRQ_DEBOUNCE_EN.
module sw_pio_irq #(
   parameter int WIDTH           = 10,
   parameter int SYNC_STAGES     = 2,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   localparam int PRIME_MAX = SYNC_STAGES + 1;
   localparam int PW        = $clog2(PRIME_MAX + 1);
   localparam logic [PW-1:0] PRIME_DONE = PW'(PRIME_MAX);

   logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] edge_raw;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] cap_clr;
   logic [31:0]      rd_mux;
   logic [PW-1:0]    prime_cnt;
   logic             primed;
   logic             wr_en;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;
   assign wr_en        = chipselect & ~write_n;
   assign sync         = sync_chain[SYNC_STAGES-1];
   assign primed       = (prime_cnt == PRIME_DONE);

   // Input synchroniser chain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_chain[k] <= '0;
         end
      end else begin
         sync_chain[0] <= in_port;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_chain[k] <= sync_chain[k-1];
         end
      end
   end

`ifdef SW_PIO_IRQ_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] db_cnt [WIDTH];

   // Per-bit stability counter: filt follows sync only after a long enough disagreement
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == filt[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               filt[i]   <= ~filt[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CW'(1);
            end
         end
      end
   end
`else
   localparam int unused_debounce = DEBOUNCE_CYCLES;
   assign filt = sync;
`endif

   // Previous filtered sample and reset priming counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev      <= '0;
         prime_cnt <= '0;
      end else begin
         prev <= filt;
         if (!primed) begin
            prime_cnt <= prime_cnt + PW'(1);
         end else begin
            prime_cnt <= prime_cnt;
         end
      end
   end

   // Edge selection; detection is held off until the input path has settled after reset
   always_comb begin
      edge_raw = '0;
      edge_hit = '0;
      case (EDGE_TYPE)
         32'sd0:  edge_raw = filt & ~prev;
         32'sd1:  edge_raw = ~filt & prev;
         32'sd2:  edge_raw = filt ^ prev;
         default: edge_raw = filt & ~prev;
      endcase
      if (primed) begin
         edge_hit = edge_raw;
      end else begin
         edge_hit = '0;
      end
   end

   // Write-one-to-clear mask for the capture register
   always_comb begin
      cap_clr = '0;
      if (wr_en && (address == 2'd3)) begin
         cap_clr = writedata[WIDTH-1:0];
      end else begin
         cap_clr = '0;
      end
   end

   // Mask and capture registers; a same-cycle edge beats the clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irqmask     <= '0;
         edgecapture <= '0;
      end else begin
         if (wr_en && (address == 2'd2)) begin
            irqmask <= writedata[WIDTH-1:0];
         end else begin
            irqmask <= irqmask;
         end
         edgecapture <= (edgecapture & ~cap_clr) | edge_hit;
      end
   end

   // Read mux
   always_comb begin
      rd_mux = 32'd0;
      case (address)
         2'd0:    rd_mux[WIDTH-1:0] = filt;
         2'd1:    rd_mux = 32'd0;
         2'd2:    rd_mux[WIDTH-1:0] = irqmask;
         2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
         default: rd_mux = 32'd0;
      endcase
   end

   // Registered read data, updated every cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= 32'd0;
      end else begin
         readdata <= rd_mux;
      end
   end

   assign irq = |(edgecapture & irqmask);

endmodule
